// File: rtl/rat_io_bus_if.sv
// rat_io_bus_if: RAT MCU port bus.
//   PORT_ID  [7:0]  port address driven by the MCU
//   OUT_PORT [7:0]  write data driven by the MCU
//   IO_STRB         write strobe driven by the MCU
//   IN_PORT  [7:0]  read data returned by the peripheral (combinational on PORT_ID)
//   INT_CU          level interrupt request returned by the peripheral (registered)
// Handshake: there is no ready/valid pair. A write is accepted on every rising
// CLK edge where IO_STRB=1; reads are always valid and need no strobe.
interface rat_io_bus_if;
  logic [7:0] PORT_ID;
  logic [7:0] OUT_PORT;
  logic       IO_STRB;
  logic [7:0] IN_PORT;
  logic       INT_CU;

  modport master (
    output PORT_ID,
    output OUT_PORT,
    output IO_STRB,
    input  IN_PORT,
    input  INT_CU
  );

  modport slave (
    input  PORT_ID,
    input  OUT_PORT,
    input  IO_STRB,
    output IN_PORT,
    output INT_CU
  );
endinterface

// File: rtl/rat_io_bus.sv
// rat_io_bus: peripheral-side responder for the RAT MCU port bus.
// Decodes port writes into LED / seven-segment / timer / interrupt registers,
// returns synchronized board inputs and status on reads, runs a 16-bit reload
// timer, detects button rising edges, and raises a maskable level interrupt.
// Ports:
//   CLK        system clock, all state on the rising edge
//   RESET_N    synchronous active-low reset
//   bus        rat_io_bus_if.slave (PORT_ID, OUT_PORT, IO_STRB, IN_PORT, INT_CU)
//   SWITCHES   [15:0] asynchronous board switches
//   BUTTONS    [3:0]  asynchronous board buttons
//   LEDS       [15:0] board LEDs
//   SSEG_DATA  [7:0]  byte to the seven-segment driver
module rat_io_bus #(
  parameter int unsigned PRESCALE = 100  // CLK cycles per timer tick, 1..65535
) (
  input  logic          CLK,
  input  logic          RESET_N,
  rat_io_bus_if.slave   bus,
  input  logic [15:0]   SWITCHES,
  input  logic [3:0]    BUTTONS,
  output logic [15:0]   LEDS,
  output logic [7:0]    SSEG_DATA
);

  localparam logic [15:0] PRESCALE_MAX = 16'(PRESCALE - 1);

  // Register state
  logic [15:0] sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
  logic [3:0]  btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
  logic [3:0]  btn_prev_q, btn_prev_d;
  logic [3:0]  btn_edge_q, btn_edge_d;
  logic [1:0]  irq_status_q, irq_status_d;
  logic [1:0]  irq_mask_q, irq_mask_d;
  logic [15:0] leds_q, leds_d;
  logic [7:0]  sseg_q, sseg_d;
  logic [15:0] tmr_reload_q, tmr_reload_d;
  logic        tmr_en_q, tmr_en_d;
  logic [15:0] tmr_cnt_q, tmr_cnt_d;
  logic [15:0] presc_q, presc_d;
  logic        int_q, int_d;

  // Combinational helpers
  logic       wr;
  logic [3:0] btn_rise;
  logic [3:0] btn_edge_clr;
  logic [1:0] irq_status_clr;
  logic       tmr_tick;
  logic       tmr_set;
  logic       tmr_start;
  logic [7:0] rd_data;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      sw_s1_q      <= '0;
      sw_s2_q      <= '0;
      btn_s1_q     <= '0;
      btn_s2_q     <= '0;
      btn_prev_q   <= '0;
      btn_edge_q   <= '0;
      irq_status_q <= '0;
      irq_mask_q   <= '0;
      leds_q       <= '0;
      sseg_q       <= '0;
      tmr_reload_q <= '0;
      tmr_en_q     <= 1'b0;
      tmr_cnt_q    <= '0;
      presc_q      <= '0;
      int_q        <= 1'b0;
    end else begin
      sw_s1_q      <= sw_s1_d;
      sw_s2_q      <= sw_s2_d;
      btn_s1_q     <= btn_s1_d;
      btn_s2_q     <= btn_s2_d;
      btn_prev_q   <= btn_prev_d;
      btn_edge_q   <= btn_edge_d;
      irq_status_q <= irq_status_d;
      irq_mask_q   <= irq_mask_d;
      leds_q       <= leds_d;
      sseg_q       <= sseg_d;
      tmr_reload_q <= tmr_reload_d;
      tmr_en_q     <= tmr_en_d;
      tmr_cnt_q    <= tmr_cnt_d;
      presc_q      <= presc_d;
      int_q        <= int_d;
    end
  end

  always_comb begin
    // Defaults: hold
    irq_mask_d     = irq_mask_q;
    leds_d         = leds_q;
    sseg_d         = sseg_q;
    tmr_reload_d   = tmr_reload_q;
    tmr_en_d       = tmr_en_q;
    tmr_cnt_d      = tmr_cnt_q;
    presc_d        = presc_q;
    btn_edge_clr   = '0;
    irq_status_clr = '0;
    tmr_tick       = 1'b0;
    tmr_set        = 1'b0;
    tmr_start      = 1'b0;

    // Two-flop synchronizers; btn_prev adds one more stage for edge detection
    sw_s1_d    = SWITCHES;
    sw_s2_d    = sw_s1_q;
    btn_s1_d   = BUTTONS;
    btn_s2_d   = btn_s1_q;
    btn_prev_d = btn_s2_q;
    btn_rise   = btn_s2_q & ~btn_prev_q;

    wr = bus.IO_STRB;

    if (wr) begin
      case (bus.PORT_ID)
        8'h25: btn_edge_clr   = bus.OUT_PORT[3:0];
        8'h30: irq_status_clr = bus.OUT_PORT[1:0];
        8'h31: irq_mask_d     = bus.OUT_PORT[1:0];
        8'h40: leds_d[7:0]    = bus.OUT_PORT;
        8'h41: leds_d[15:8]   = bus.OUT_PORT;
        8'h50: tmr_reload_d[7:0]  = bus.OUT_PORT;
        8'h51: tmr_reload_d[15:8] = bus.OUT_PORT;
        8'h52: begin
          tmr_en_d  = bus.OUT_PORT[0];
          tmr_start = bus.OUT_PORT[0] & ~tmr_en_q;
        end
        8'h81: sseg_d = bus.OUT_PORT;
        default: ;
      endcase
    end

    // Timer: a 0->1 enable write restarts the count; otherwise count only
    // while enabled. Reload always uses the currently stored reload value, so
    // a reload write on the same edge takes effect at the following reload.
    if (tmr_start) begin
      tmr_cnt_d = tmr_reload_q;
      presc_d   = '0;
    end else if (tmr_en_q) begin
      if (presc_q == PRESCALE_MAX) begin
        presc_d  = '0;
        tmr_tick = 1'b1;
      end else begin
        presc_d = presc_q + 16'd1;
      end
      if (tmr_tick) begin
        if (tmr_cnt_q == 16'd0) begin
          tmr_cnt_d = tmr_reload_q;
          tmr_set   = 1'b1;
        end else begin
          tmr_cnt_d = tmr_cnt_q - 16'd1;
        end
      end
    end

    // Hardware set is applied after the W1C so a same-edge collision keeps the bit
    btn_edge_d   = (btn_edge_q & ~btn_edge_clr) | btn_rise;
    irq_status_d = (irq_status_q & ~irq_status_clr) | {(|btn_rise), tmr_set};

    // Interrupt registered from current status, so it lags status by one cycle
    int_d = |(irq_status_q & irq_mask_q);
  end

  always_comb begin
    rd_data = 8'h00;
    case (bus.PORT_ID)
      8'h20: rd_data = sw_s2_q[7:0];
      8'h21: rd_data = sw_s2_q[15:8];
      8'h24: rd_data = {4'h0, btn_s2_q};
      8'h25: rd_data = {4'h0, btn_edge_q};
      8'h30: rd_data = {6'h00, irq_status_q};
      8'h31: rd_data = {6'h00, irq_mask_q};
      8'h40: rd_data = leds_q[7:0];
      8'h41: rd_data = leds_q[15:8];
      8'h50: rd_data = tmr_reload_q[7:0];
      8'h51: rd_data = tmr_reload_q[15:8];
      8'h52: rd_data = {7'h00, tmr_en_q};
      8'h81: rd_data = sseg_q;
      default: rd_data = 8'h00;
    endcase
  end

  assign bus.IN_PORT = rd_data;
  assign bus.INT_CU  = int_q;
  assign LEDS        = leds_q;
  assign SSEG_DATA   = sseg_q;

endmodule

// File: tb/tb_rat_io_bus.sv
// tb_rat_io_bus: directed bench for rat_io_bus (PRESCALE=4).
// Each cycle step drives the bus just after a rising edge; expectations queued
// before that step are compared by the monitor at the following falling edge.
module tb_rat_io_bus;

  localparam int K_IN   = 0;
  localparam int K_INT  = 1;
  localparam int K_LEDS = 2;
  localparam int K_SSEG = 3;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] switches;
  logic [3:0]  buttons;
  logic [15:0] leds;
  logic [7:0]  sseg;

  rat_io_bus_if bus();

  rat_io_bus #(.PRESCALE(4)) dut (
    .CLK       (clk),
    .RESET_N   (rst_n),
    .bus       (bus),
    .SWITCHES  (switches),
    .BUTTONS   (buttons),
    .LEDS      (leds),
    .SSEG_DATA (sseg)
  );

  // Scoreboard
  logic [15:0] exp_q[$];
  int          kind_q[$];
  string       name_q[$];
  int pend   = 0;
  int chk_n  = 0;
  int checks = 0;
  int errors = 0;

  task automatic expect_val(input int kind, input logic [15:0] v, input string name);
    exp_q.push_back(v);
    kind_q.push_back(kind);
    name_q.push_back(name);
    pend++;
  endtask

  // Driver: one clock cycle
  task automatic cyc(input logic r, input logic [7:0] id, input logic [7:0] d, input logic s);
    @(posedge clk);
    #1;
    rst_n        = r;
    bus.PORT_ID  = id;
    bus.OUT_PORT = d;
    bus.IO_STRB  = s;
    chk_n        = pend;
    pend         = 0;
  endtask

  task automatic rd(input logic [7:0] id, input logic [7:0] v, input string name);
    expect_val(K_IN, {8'h00, v}, name);
    cyc(1'b1, id, 8'h00, 1'b0);
  endtask

  task automatic wr(input logic [7:0] id, input logic [7:0] d);
    cyc(1'b1, id, d, 1'b1);
  endtask

  // Timer-phase IRQ_STATUS[0] profile, indexed by cycles since the enable write
  function automatic logic st(input int k);
    return (k >= 13 && k <= 15) || (k >= 25 && k <= 26) || (k >= 37);
  endfunction

  // Monitor
  int          m_kind;
  logic [15:0] m_exp;
  logic [15:0] m_act;
  string       m_name;
  always @(negedge clk) begin
    for (int i = 0; i < chk_n; i++) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow: got empty queue required entry");
        break;
      end
      m_kind = kind_q.pop_front();
      m_exp  = exp_q.pop_front();
      m_name = name_q.pop_front();
      case (m_kind)
        K_IN:    m_act = {8'h00, bus.IN_PORT};
        K_INT:   m_act = {15'h0000, bus.INT_CU};
        K_LEDS:  m_act = leds;
        default: m_act = {8'h00, sseg};
      endcase
      checks++;
      if (m_act !== m_exp) begin
        errors++;
        $display("FAIL %s: got %h required %h", m_name, m_act, m_exp);
      end
    end
    chk_n = 0;
  end

  initial begin
    rst_n        = 1'b0;
    switches     = 16'h0000;
    buttons      = 4'h0;
    bus.PORT_ID  = 8'h00;
    bus.OUT_PORT = 8'h00;
    bus.IO_STRB  = 1'b0;

    // Reset beats a held write strobe
    cyc(1'b0, 8'h40, 8'hAA, 1'b1);
    expect_val(K_LEDS, 16'h0000, "rst_leds");
    expect_val(K_INT,  16'h0000, "rst_int");
    expect_val(K_IN,   16'h0000, "rst_rd40");
    cyc(1'b0, 8'h40, 8'hAA, 1'b1);
    expect_val(K_LEDS, 16'h0000, "rst_leds_hold");
    cyc(1'b1, 8'h40, 8'hAA, 1'b1);
    expect_val(K_LEDS, 16'h00AA, "leds_lo");
    expect_val(K_IN,   16'h00AA, "rd_40");
    cyc(1'b1, 8'h40, 8'h00, 1'b0);
    rd(8'h41, 8'h00, "rd_41");
    wr(8'h41, 8'h12);
    wr(8'h81, 8'h5A);
    expect_val(K_LEDS, 16'h12AA, "leds_hi");
    expect_val(K_SSEG, 16'h005A, "sseg");
    rd(8'h81, 8'h5A, "rd_81");

    // Switch readback through the synchronizer
    switches = 16'hBEEF;
    rd(8'h20, 8'h00, "sw_lat1");
    rd(8'h20, 8'hEF, "sw_lo");
    rd(8'h21, 8'hBE, "sw_hi");
    rd(8'h77, 8'h00, "unmapped");

    // Timer: reload=2, mask timer, enable
    wr(8'h50, 8'h02);
    wr(8'h51, 8'h00);
    wr(8'h31, 8'h01);
    wr(8'h52, 8'h01);
    for (int k = 1; k <= 38; k++) begin
      expect_val(K_IN,  {15'h0000, st(k)},     $sformatf("tmr_status_k%0d", k));
      expect_val(K_INT, {15'h0000, st(k - 1)}, $sformatf("tmr_int_k%0d", k));
      // k=15 and k=26 clear; k=36 collides with the reload tick at k=37
      if (k == 15 || k == 26 || k == 36)
        cyc(1'b1, 8'h30, 8'h01, 1'b1);
      else
        cyc(1'b1, 8'h30, 8'h00, 1'b0);
    end

    // Mid-operation reset with interrupt asserted
    expect_val(K_IN,  16'h0001, "tmr_en_before_rst");
    expect_val(K_INT, 16'h0001, "int_before_rst");
    cyc(1'b0, 8'h52, 8'h00, 1'b0);
    expect_val(K_IN,   16'h0000, "tmr_en_after_rst");
    expect_val(K_INT,  16'h0000, "int_after_rst");
    expect_val(K_LEDS, 16'h0000, "leds_after_rst");
    cyc(1'b1, 8'h52, 8'h00, 1'b0);
    rd(8'h50, 8'h00, "reload_after_rst");
    for (int k = 0; k < 20; k++) begin
      expect_val(K_INT, 16'h0000, $sformatf("quiet_int_%0d", k));
      rd(8'h30, 8'h00, $sformatf("quiet_status_%0d", k));
    end

    // Button edge, mask off then on, then W1C
    buttons = 4'b0100;
    rd(8'h24, 8'h00, "btn_lat1");
    rd(8'h24, 8'h04, "btn_sync");
    rd(8'h25, 8'h04, "btn_edge");
    expect_val(K_INT, 16'h0000, "btn_int_masked");
    rd(8'h30, 8'h02, "btn_status");
    expect_val(K_INT, 16'h0000, "btn_int_masked2");
    rd(8'h31, 8'h00, "mask_zero");
    expect_val(K_INT, 16'h0000, "btn_int_masked3");
    wr(8'h31, 8'h02);
    expect_val(K_INT, 16'h0000, "btn_int_lag");
    rd(8'h31, 8'h02, "mask_btn");
    expect_val(K_INT, 16'h0001, "btn_int_on");
    expect_val(K_IN,  16'h0004, "btn_edge_pre_clr");
    wr(8'h25, 8'h04);
    expect_val(K_INT, 16'h0001, "btn_int_still");
    expect_val(K_IN,  16'h0002, "btn_status_pre_clr");
    wr(8'h30, 8'h02);
    expect_val(K_INT, 16'h0001, "btn_int_lag_clr");
    rd(8'h25, 8'h00, "btn_edge_clr");
    expect_val(K_INT, 16'h0000, "btn_int_off");
    rd(8'h30, 8'h00, "btn_status_clr");

    cyc(1'b1, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rat_io_bus.md
Name: rat_io_bus

Overview:
- Peripheral-side responder for the RAT MCU port bus. Decodes PORT_ID and captures OUT_PORT into output registers when IO_STRB is high.
- Drives IN_PORT from synchronized board inputs and status registers.
- Contains a 16-bit reload timer and button-edge detection, both of which feed a maskable level interrupt into the MCU INT_CU input.
- Instantiated in the Basys3 top level beside the MCU.

Parameters:
- PRESCALE, 100: CLK cycles per timer tick (1 MHz at 100 MHz). Legal range 1..65535.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RESET_N  in  1  synchronous active-low reset.
- PORT_ID  in  8  port address from the MCU.
- OUT_PORT  in  8  write data from the MCU.
- IO_STRB  in  1  write strobe from the MCU.
- IN_PORT  out  8  read data to the MCU; combinational on PORT_ID.
- INT_CU  out  1  interrupt request to the MCU; level, registered.
- SWITCHES  in  16  board switches; asynchronous.
- BUTTONS  in  4  board buttons; asynchronous.
- LEDS  out  16  board LEDs.
- SSEG_DATA  out  8  byte to the seven-segment driver.

Behaviour:
- Reset: RESET_N=0 sampled at a CLK edge clears every register to 0 (LEDS, SSEG_DATA, IRQ_STATUS, IRQ_MASK, BTN_EDGE, TMR_RELOAD, TMR_CTRL, counter, prescaler, synchronizers) and drives INT_CU=0. Reset has priority over everything, including mid-count and a pending interrupt.
- Port map (R = read, W = write, W1C = write-1-to-clear):
  - 0x20 R: SWITCHES[7:0], synchronized.
  - 0x21 R: SWITCHES[15:8], synchronized.
  - 0x24 R: BUTTONS, synchronized, in bits [3:0]; bits [7:4] read 0.
  - 0x25 R/W1C: BTN_EDGE[3:0].
  - 0x30 R/W1C: IRQ_STATUS. Bit0 = timer, bit1 = button; bits [7:2] read 0.
  - 0x31 R/W: IRQ_MASK[1:0].
  - 0x40 R/W: LEDS[7:0].
  - 0x41 R/W: LEDS[15:8].
  - 0x50 R/W: TMR_RELOAD[7:0].
  - 0x51 R/W: TMR_RELOAD[15:8].
  - 0x52 R/W: TMR_CTRL bit0 = EN.
  - 0x81 R/W: SSEG_DATA.
  - Unmapped reads return 0x00. Unmapped writes are ignored.
- Writes: on a CLK edge with IO_STRB=1, decode PORT_ID and update the target register. New values are visible on outputs the next cycle. If IO_STRB is held for several cycles, the write repeats each cycle; this is idempotent, including W1C.
- Reads: IN_PORT is a purely combinational mux of register values and is independent of IO_STRB.
- Synchronizers: SWITCHES and BUTTONS each pass through 2 flops; readback latency is 2 cycles.
- Button edges: a 0->1 transition on a synchronized button bit sets that BTN_EDGE bit and sets IRQ_STATUS[1].
- Timer:
  - Writing 0x52 with EN going 0->1 loads counter=TMR_RELOAD and clears the prescaler.
  - While EN=1, the prescaler counts 0..PRESCALE-1. A tick occurs when it wraps.
  - On a tick: if counter==0, reload counter=TMR_RELOAD and set IRQ_STATUS[0]; otherwise decrement counter.
  - With TMR_RELOAD=0, IRQ_STATUS[0] sets on every tick.
  - EN=0 freezes the counter and prescaler.
  - Writing TMR_RELOAD while running does not affect the current count; the new value takes effect at the next reload.
- Simultaneous set and clear: if a hardware set and a W1C of the same bit occur on the same edge, set wins and the bit stays 1.
- Interrupt: INT_CU is a register equal to |(IRQ_STATUS & IRQ_MASK[1:0]), updated every cycle, so it lags status by 1 cycle. It stays asserted until software clears the status bit or the mask bit.

Test Plan:
- Reset: hold RESET_N=0 for 2 cycles with IO_STRB=1, PORT_ID=0x40, OUT_PORT=0xAA -> LEDS=0x0000, INT_CU=0, IN_PORT at 0x40 reads 0x00. Then release RESET_N and strobe the same write -> LEDS[7:0]=0xAA the next cycle; 0x41 reads 0x00.
- Input readback: SWITCHES=0xBEEF -> after 2 cycles, reading 0x20 gives 0xEF and 0x21 gives 0xBE. Reading PORT_ID=0x77 gives 0x00.
- Timer: PRESCALE=4, write 0x50=0x02, 0x51=0x00, 0x31=0x01, 0x52=0x01 -> IRQ_STATUS[0] sets 12 cycles after EN is written (3 ticks: 2->1->0->reload), and INT_CU rises 1 cycle later. Then write 0x30=0x01 -> INT_CU falls within 2 cycles; the next set occurs 12 cycles after the previous one.
- Button edge with mask off: raise BUTTONS[2] with IRQ_MASK=0 -> 0x25 reads 0x04 and 0x30 reads 0x02, but INT_CU stays 0. Then write 0x31=0x02 -> INT_CU=1. Then write 0x25=0x04 and 0x30=0x02 -> both read 0 and INT_CU=0.
- Set/clear collision: arrange a timer reload tick on the same edge as a write of 0x30=0x01 -> IRQ_STATUS[0] remains 1.
- Mid-operation reset: assert RESET_N=0 for 1 cycle while the timer is running with INT_CU=1 -> INT_CU=0, TMR_CTRL=0, the counter is frozen at 0, and no further IRQ occurs.
